// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with PLL-style lock indicator.
// Latency: outputs register the counter state one refclk edge later.
// Backpressure: cfg_ready low while locking/reconfiguring; requests are not queued.
module clk_div_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outen,
    output logic              locked
);

    localparam int                LC_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LC_W-1:0]   LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_LOCKING  = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_RECONFIG = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [LC_W-1:0]               lock_cnt_q, lock_cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]             gate_q, gate_d;
    logic [NUM_CH-1:0]             outclk_q, outclk_d;
    logic [NUM_CH-1:0]             outen_q, outen_d;
    logic                          ready_q, ready_d;
    logic                          err_q, err_d;

    logic lock_done;
    logic req_ok;
    logic load;
    logic release_gate;

    always_comb begin
        lock_done    = (lock_cnt_q == LOCK_LAST);
        req_ok       = (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div) &&
                       ({1'b0, cfg_ch} < CH_LIMIT);
        load         = 1'b0;
        release_gate = 1'b0;
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        ready_d      = ready_q;
        err_d        = 1'b0;

        case (state_q)
            ST_LOCKING: begin
                lock_cnt_d = lock_cnt_q + LC_W'(1);
                if (lock_done) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = '0;
                    ready_d    = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (cfg_valid && ready_q) begin
                    if (req_ok) begin
                        load       = 1'b1;
                        state_d    = ST_RECONFIG;
                        lock_cnt_d = '0;
                        ready_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECONFIG: begin
                lock_cnt_d = lock_cnt_q + LC_W'(1);
                if (lock_done) begin
                    release_gate = 1'b1;
                    state_d      = ST_LOCKED;
                    ready_d      = 1'b1;
                end
            end
            default: begin
                state_d    = ST_LOCKING;
                lock_cnt_d = '0;
                ready_d    = 1'b0;
            end
        endcase

        div_d    = div_q;
        cnt_d    = cnt_q;
        gate_d   = gate_q;
        outclk_d = '0;
        outen_d  = '0;
        // The release edge already runs the channel, so its first output decodes the loaded phase.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gate_q[i] || release_gate) begin
                outclk_d[i] = (cnt_q[i] < (div_q[i] >> 1));
                outen_d[i]  = (cnt_q[i] == '0);
                cnt_d[i]    = (cnt_q[i] == div_q[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
                gate_d[i]   = 1'b0;
            end
            if (load && (cfg_ch == CH_W'(i))) begin
                div_d[i]    = cfg_div;
                cnt_d[i]    = cfg_phase;
                gate_d[i]   = 1'b1;
                outclk_d[i] = 1'b0;
                outen_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKING;
            lock_cnt_q <= '0;
            div_q      <= {NUM_CH{DIV_RST}};
            cnt_q      <= '0;
            gate_q     <= '0;
            outclk_q   <= '0;
            outen_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            gate_q     <= gate_d;
            outclk_q   <= outclk_d;
            outen_q    <= outen_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Lock and config-ready are the same condition: steady state with nothing settling.
    assign locked    = ready_q;
    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign outclk    = outclk_q;
    assign outen     = outen_q;

endmodule
